// File: rtl/iiitb_pwm_pkg.sv
// Shared encodings for the multi-channel PWM: counter mode and counter direction.
package iiitb_pwm_pkg;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/iiitb_pwm_debounce.sv
// Tick-enabled two-flop button sampler producing one pulse per press.
module iiitb_pwm_debounce (
   input  logic clk,
   input  logic rst_n,
   input  logic i_tick,
   input  logic i_btn,
   output logic o_pulse
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else if (i_tick) begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
      end
   end

   assign o_pulse = r_s1 & ~r_s2 & i_tick;

endmodule

// File: rtl/iiitb_pwm_multi.sv
// Multi-channel PWM with shared edge/center-aligned counter and per-channel
// button-stepped duty; period, mode and duties update only at the period boundary.
module iiitb_pwm_multi
   import iiitb_pwm_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int CW         = 8,
   parameter int DEB_DIV    = 2,
   parameter int RESET_DUTY = 5
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [CW-1:0]                          period,
   input  logic                                   mode,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel,
   input  logic                                   increase_duty,
   input  logic                                   decrease_duty,
   output logic [NCH-1:0]                         pwm_out
);

   localparam int              SW        = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int              DW        = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
   localparam logic [DW-1:0]   DIV_LAST  = DW'(DEB_DIV - 1);
   localparam logic [CW:0]     DUTY_RST  = (CW+1)'(RESET_DUTY);
   localparam logic [CW-1:0]   P_RST     = {CW{1'b1}};

   logic [DW-1:0]  r_div;
   logic           w_tick;
   logic           w_inc;
   logic           w_dec;
   logic [CW:0]    r_shadow [NCH];
   logic [CW:0]    r_duty   [NCH];
   logic [CW-1:0]  r_p_act;
   logic           r_mode_act;
   logic [CW-1:0]  r_cnt;
   logic           r_dir;
   logic [NCH-1:0] r_pwm;
   logic [CW:0]    w_full;
   logic           w_bnd;

   // Clamp a stale shadow value to the current 100 % level, then step it.
   function automatic logic [CW:0] f_step(input logic [CW:0] d, input logic [CW:0] full,
                                          input logic inc, input logic dec);
      logic [CW:0] c;
      c = (d > full) ? full : d;
      if (inc && !dec)      f_step = (c == full) ? full : c + 1'b1;
      else if (dec && !inc) f_step = (c == '0) ? c : c - 1'b1;
      else                  f_step = d;
   endfunction

   assign w_tick = (r_div == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_div <= '0;
      else        r_div <= w_tick ? '0 : r_div + 1'b1;
   end

   iiitb_pwm_debounce u_deb_inc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_tick  (w_tick),
      .i_btn   (increase_duty),
      .o_pulse (w_inc)
   );

   iiitb_pwm_debounce u_deb_dec (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_tick  (w_tick),
      .i_btn   (decrease_duty),
      .o_pulse (w_dec)
   );

   assign w_full = {1'b0, r_p_act} + 1'b1;

   // ch_sel values at or above NCH never match a loop index, so they are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) r_shadow[k] <= DUTY_RST;
      end else if (w_inc || w_dec) begin
         for (int k = 0; k < NCH; k++)
            if (ch_sel == SW'(k))
               r_shadow[k] <= f_step(r_shadow[k], w_full, w_inc, w_dec);
      end
   end

   always_comb begin
      w_bnd = 1'b0;
      if (r_p_act == '0)               w_bnd = 1'b1;
      else if (r_mode_act == MODE_EDGE) w_bnd = (r_cnt == r_p_act);
      else                             w_bnd = (r_cnt == r_p_act) && (r_dir == DIR_DOWN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_dir      <= DIR_UP;
         r_p_act    <= P_RST;
         r_mode_act <= MODE_EDGE;
         for (int k = 0; k < NCH; k++) r_duty[k] <= DUTY_RST;
      end else begin
         if (w_bnd) begin
            r_p_act    <= period;
            r_mode_act <= mode;
            for (int k = 0; k < NCH; k++) r_duty[k] <= r_shadow[k];
         end
         if ((w_bnd && (mode != r_mode_act)) || (r_p_act == '0)) begin
            r_cnt <= '0;
            r_dir <= DIR_UP;
         end else if (r_mode_act == MODE_EDGE) begin
            r_cnt <= (r_cnt == r_p_act) ? '0 : r_cnt + 1'b1;
            r_dir <= DIR_UP;
         end else if (r_dir == DIR_UP) begin
            // The top value is held for one extra cycle while the direction turns.
            if (r_cnt == r_p_act) r_dir <= DIR_DOWN;
            else                  r_cnt <= r_cnt + 1'b1;
         end else begin
            if (r_cnt == '0) r_dir <= DIR_UP;
            else             r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) r_pwm[k] <= ({1'b0, r_cnt} < r_duty[k]);
      end
   end

   assign pwm_out = r_pwm;

endmodule

// File: tb/tb_iiitb_pwm_multi.sv
// Scoreboard bench for iiitb_pwm_multi (NCH=4, CW=4, DEB_DIV=2, RESET_DUTY=5).
module tb_iiitb_pwm_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] period = 4'd9;
   logic       mode = 1'b0;
   logic [1:0] ch_sel = 2'd0;
   logic       inc = 1'b0;
   logic       dec = 1'b0;
   logic [3:0] pwm_out;

   iiitb_pwm_multi #(.NCH(4), .CW(4), .DEB_DIV(2), .RESET_DUTY(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .period        (period),
      .mode          (mode),
      .ch_sel        (ch_sel),
      .increase_duty (inc),
      .decrease_duty (dec),
      .pwm_out       (pwm_out)
   );

   always #5 clk = ~clk;

   // Cycle index: number of rising edges since reset release.
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   typedef struct {
      int         cyc;
      logic [3:0] exp;
      string      name;
   } item_t;

   item_t q[$];
   int checks = 0;
   int failures = 0;

   task automatic push(input int c, input logic [3:0] e, input string n);
      item_t it;
      it.cyc = c; it.exp = e; it.name = n;
      q.push_back(it);
   endtask

   task automatic exp_const(input int c0, input int c1, input logic [3:0] e, input string n);
      for (int c = c0; c <= c1; c++) push(c, e, n);
   endtask

   // Edge mode, P=9: a period starting at cycle 'start' is high for its first d[k] cycles.
   task automatic exp_edge(input int start, input int nper, input int d0, input int d1,
                           input int d2, input int d3, input string n);
      int d[4];
      logic [3:0] e;
      d = '{d0, d1, d2, d3};
      for (int p = 0; p < nper; p++)
         for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 4; k++) e[k] = (j < d[k]);
            push(start + p*10 + j, e, n);
         end
   endtask

   // Center mode, P=4, duties {2,0,6,5}: ch0 high on j=0,1,8,9; ch1 low; ch2/ch3 saturated high.
   task automatic exp_center(input int start, input int nper, input string n);
      logic [3:0] e;
      for (int p = 0; p < nper; p++)
         for (int j = 0; j < 10; j++) begin
            e = {2'b11, 1'b0, ((j < 2) || (j >= 8))};
            push(start + p*10 + j, e, n);
         end
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int t, input logic up, input logic down);
      goto(t);
      inc = up;
      dec = down;
      goto(t + 4);
      inc = 1'b0;
      dec = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s cyc=%0d not sampled (now %0d)", q[0].name, q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            checks++;
            if (pwm_out !== q[0].exp) begin
               failures++;
               $display("FAIL %s cyc=%0d pwm_out=%b expected=%b", q[0].name, cyc, pwm_out, q[0].exp);
            end
            void'(q.pop_front());
         end
      end
   end

   initial begin
      push(0, 4'b0000, "reset_state");
      exp_const(1, 5, 4'b1111, "first_period_hi");
      exp_const(6, 16, 4'b0000, "first_period_lo");
      exp_edge(17, 2, 5, 5, 5, 5, "duty5");
      exp_edge(37, 3, 5, 5, 6, 5, "ch2_inc");
      exp_edge(67, 1, 5, 6, 6, 5, "ch1_step6");
      exp_edge(107, 6, 5, 10, 6, 5, "ch1_sat_high");
      exp_edge(247, 6, 5, 0, 6, 5, "ch1_sat_low_both");
      exp_edge(307, 1, 4, 0, 6, 5, "ch0_dec4");
      exp_edge(317, 1, 3, 0, 6, 5, "ch0_dec3");
      exp_edge(327, 1, 2, 0, 6, 5, "ch0_dec2");
      exp_center(337, 4, "center");
      exp_edge(383, 1, 2, 0, 6, 5, "back_to_edge");
      exp_edge(393, 1, 2, 0, 6, 6, "ch3_inc6");
      exp_edge(403, 1, 2, 0, 6, 7, "ch3_inc7");
      exp_edge(413, 2, 2, 0, 6, 8, "ch3_duty8");

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      goto(30);
      ch_sel = 2'd2;
      inc = 1'b1;
      goto(50);
      inc = 1'b0;

      ch_sel = 2'd1;
      for (int i = 0; i < 12; i++) press(60 + 8*i, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) press(160 + 8*i, 1'b0, 1'b1);

      ch_sel = 2'd2;
      press(270, 1'b1, 1'b1);

      ch_sel = 2'd0;
      for (int i = 0; i < 3; i++) press(300 + 8*i, 1'b0, 1'b1);

      goto(327);
      mode = 1'b1;
      period = 4'd4;
      goto(377);
      mode = 1'b0;
      period = 4'd9;
      ch_sel = 2'd3;
      for (int i = 0; i < 3; i++) press(384 + 8*i, 1'b1, 1'b0);

      goto(436);
      #2 rst_n = 1'b0;
      push(0, 4'b0000, "async_reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_const(1, 5, 4'b1111, "post_reset_hi");
      exp_const(6, 16, 4'b0000, "post_reset_lo");
      exp_edge(17, 3, 5, 5, 5, 5, "post_reset_duty5");

      for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
